// File: rtl/pc_sequencer.sv
// pc_sequencer
// ------------
// Program-counter sequencer at the front of the fetch path. Each cycle it
// performs exactly one action, chosen by priority:
//   stall > ret > call > jump > branch > increment
// It keeps a small hardware return stack for call/ret and two sticky error
// flags for stack overflow and underflow.
//
// Parameters:
//   WIDTH     - PC / address width in bits (>= 4)
//   STEP      - sequential increment (1 <= STEP < 2**WIDTH)
//   DEPTH     - return-stack entries (>= 1)
//   RESET_VEC - PC value after reset
//
// Ports:
//   clk        in   clock, rising-edge
//   rst_n      in   asynchronous reset, ACTIVE HIGH (the name is historical)
//   stall      in   hold pc, sp and stack this cycle
//   jump_en    in   pc <= target
//   branch_en  in   pc <= pc + signed(target)
//   call_en    in   push pc+STEP, pc <= target
//   ret_en     in   pop the stack into pc
//   target     in   jump/call address or branch offset (two's complement)
//   clr_err    in   clear the sticky error flags
//   pc         out  registered program counter
//   sp         out  number of valid stack entries
//   stk_full   out  sp == DEPTH
//   stk_empty  out  sp == 0
//   ovf_err    out  sticky, set by a call into a full stack
//   unf_err    out  sticky, set by a return from an empty stack
//
// Control handshake: none. Every enable is a single-cycle level that is
// sampled on the rising edge of clk, and the result is visible on pc/sp
// right after that edge.

module pc_sequencer #(
    parameter int WIDTH     = 8,
    parameter int STEP      = 4,
    parameter int DEPTH     = 4,
    parameter int RESET_VEC = 0,
    localparam int SPW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             jump_en,
    input  logic             branch_en,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic [WIDTH-1:0] target,
    input  logic             clr_err,
    output logic [WIDTH-1:0] pc,
    output logic [SPW-1:0]   sp,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             ovf_err,
    output logic             unf_err
);

    // The stack is addressed with an index exactly as wide as it needs to be.
    // Rounding the array up to a power of two keeps every index in range.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VEC);
    localparam logic [SPW-1:0]   DEPTH_S = SPW'(DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] stack_q [2**AW];

    logic             push;
    logic             ovf_set;
    logic             unf_set;
    logic [WIDTH-1:0] pc_inc;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    pop_idx;

    assign pc_inc   = pc_q + STEP_W;
    assign push_idx = AW'(sp_q);
    assign pop_idx  = AW'(sp_q - SPW'(1));

    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (stall) begin
            // hold everything
        end else if (ret_en) begin
            if (sp_q != '0) begin
                pc_d = stack_q[pop_idx];
                sp_d = sp_q - SPW'(1);
            end else begin
                unf_set = 1'b1;
                pc_d    = pc_inc;
            end
        end else if (call_en) begin
            if (sp_q != DEPTH_S) begin
                push = 1'b1;
                sp_d = sp_q + SPW'(1);
                pc_d = target;
            end else begin
                // The jump is dropped too, so a later ret can never land on a
                // return address that was never saved.
                ovf_set = 1'b1;
                pc_d    = pc_inc;
            end
        end else if (jump_en) begin
            pc_d = target;
        end else if (branch_en) begin
            // A modular add of the raw bits is the same as adding the signed
            // offset and truncating to WIDTH.
            pc_d = pc_q + target;
        end else begin
            pc_d = pc_inc;
        end

        // A new error event wins over a simultaneous clear.
        ovf_d = (ovf_q & ~clr_err) | ovf_set;
        unf_d = (unf_q & ~clr_err) | unf_set;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pc_q  <= RESET_W;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack contents are don't-care after reset, so this storage has no reset.
    always_ff @(posedge clk) begin
        if (push && !rst_n) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign pc        = pc_q;
    assign sp        = sp_q;
    assign stk_full  = (sp_q == DEPTH_S);
    assign stk_empty = (sp_q == '0);
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int W     = 8;
  localparam int STEP  = 4;
  localparam int DEPTH = 4;
  localparam int MOD   = 1 << W;
  localparam int SPW   = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           stall = 1'b0;
  logic           jump_en = 1'b0;
  logic           branch_en = 1'b0;
  logic           call_en = 1'b0;
  logic           ret_en = 1'b0;
  logic [W-1:0]   target = '0;
  logic           clr_err = 1'b0;
  logic [W-1:0]   pc;
  logic [SPW-1:0] sp;
  logic           stk_full;
  logic           stk_empty;
  logic           ovf_err;
  logic           unf_err;

  always #5 clk = ~clk;

  pc_sequencer #(.WIDTH(W), .STEP(STEP), .DEPTH(DEPTH), .RESET_VEC(0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump_en(jump_en),
    .branch_en(branch_en), .call_en(call_en), .ret_en(ret_en),
    .target(target), .clr_err(clr_err), .pc(pc), .sp(sp),
    .stk_full(stk_full), .stk_empty(stk_empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  // ---------------- reference model ----------------
  // Program counter as a plain integer, return stack as a queue.
  int m_pc;
  int m_stk[$];
  bit m_ovf;
  bit m_unf;

  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step(input bit s, input bit r, input bit c, input bit j,
                            input bit b, input int t, input bit ce);
    int off;
    if (ce) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (s) begin
      // nothing moves
    end else if (r) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin
        m_unf = 1;
        m_pc = (m_pc + STEP) % MOD;
      end
    end else if (c) begin
      if (m_stk.size() < DEPTH) begin
        m_stk.push_back((m_pc + STEP) % MOD);
        m_pc = t;
      end else begin
        m_ovf = 1;
        m_pc = (m_pc + STEP) % MOD;
      end
    end else if (j) begin
      m_pc = t;
    end else if (b) begin
      off = (t >= MOD / 2) ? t - MOD : t;
      m_pc = (m_pc + off + MOD) % MOD;
    end else begin
      m_pc = (m_pc + STEP) % MOD;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".sp"}, 32'(sp), 32'(m_stk.size()));
    chk({tag, ".full"}, 32'(stk_full), 32'(m_stk.size() == DEPTH));
    chk({tag, ".empty"}, 32'(stk_empty), 32'(m_stk.size() == 0));
    chk({tag, ".ovf"}, 32'(ovf_err), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(unf_err), 32'(m_unf));
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input string tag, input bit s, input bit r, input bit c,
                          input bit j, input bit b, input int t, input bit ce);
    stall = s; ret_en = r; call_en = c; jump_en = j; branch_en = b;
    target = W'(t); clr_err = ce;
    model_step(s, r, c, j, b, t, ce);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    do_cycle(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- directed + random steps ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b0;

    // 1. free run and wrap
    for (int i = 0; i < 5; i++) idle("free");
    chk("free.pc20", 32'(pc), 32'h14);
    do_cycle("jmpFC", 0, 0, 0, 1, 0, 'hFC, 0);
    idle("wrap");
    chk("wrap.pc0", 32'(pc), 32'h00);

    // 2. priority and stall
    do_cycle("jmp10", 0, 0, 0, 1, 0, 'h10, 0);
    do_cycle("jmp80", 0, 0, 0, 1, 0, 'h80, 0);
    chk("jmp80.pc", 32'(pc), 32'h80);
    do_cycle("stall", 1, 0, 0, 1, 0, 'h20, 0);
    chk("stall.pc", 32'(pc), 32'h80);
    do_cycle("jmp_over_br", 0, 0, 0, 1, 1, 'h20, 0);
    chk("jmp_over_br.pc", 32'(pc), 32'h20);

    // 3. branch wrap both ways
    do_cycle("jmp04", 0, 0, 0, 1, 0, 'h04, 0);
    do_cycle("br_neg", 0, 0, 0, 0, 1, 'hF8, 0);
    chk("br_neg.pc", 32'(pc), 32'hFC);
    do_cycle("jmpF0", 0, 0, 0, 1, 0, 'hF0, 0);
    do_cycle("br_pos", 0, 0, 0, 0, 1, 'h20, 0);
    chk("br_pos.pc", 32'(pc), 32'h10);

    // 4. call / return nesting
    do_cycle("jmp00", 0, 0, 0, 1, 0, 'h00, 0);
    do_cycle("call40", 0, 0, 1, 0, 0, 'h40, 0);
    do_cycle("call80", 0, 0, 1, 0, 0, 'h80, 0);
    do_cycle("ret1", 0, 1, 0, 0, 0, 0, 0);
    chk("ret1.pc", 32'(pc), 32'h44);
    do_cycle("ret2", 0, 1, 0, 0, 0, 0, 0);
    chk("ret2.pc", 32'(pc), 32'h04);
    chk("ret2.empty", 32'(stk_empty), 32'h1);

    // 5. overflow / underflow
    for (int i = 0; i < DEPTH; i++) do_cycle("fill", 0, 0, 1, 0, 0, 16 * (i + 1), 0);
    chk("fill.full", 32'(stk_full), 32'h1);
    do_cycle("ovf_call", 0, 0, 1, 0, 0, 'hA0, 0);
    chk("ovf_call.pc", 32'(pc), 32'h44);
    chk("ovf_call.ovf", 32'(ovf_err), 32'h1);
    do_cycle("ovf_stall_call", 1, 0, 1, 0, 0, 'hA0, 1);
    chk("stall_clr.ovf", 32'(ovf_err), 32'h0);
    do_cycle("ovf_again", 0, 0, 1, 0, 0, 'hA0, 0);
    for (int i = 0; i < DEPTH; i++) do_cycle("drain", 0, 1, 0, 0, 0, 0, 0);
    do_cycle("unf_ret", 0, 1, 0, 0, 0, 0, 0);
    chk("unf_ret.unf", 32'(unf_err), 32'h1);
    do_cycle("clr", 0, 0, 0, 0, 0, 0, 1);
    chk("clr.ovf", 32'(ovf_err), 32'h0);
    chk("clr.unf", 32'(unf_err), 32'h0);
    do_cycle("clr_and_unf", 0, 1, 0, 0, 0, 0, 1);
    chk("clr_and_unf.unf", 32'(unf_err), 32'h1);

    // 6. asynchronous reset between edges
    do_cycle("c10", 0, 0, 1, 0, 0, 'h10, 0);
    do_cycle("c20", 0, 0, 1, 0, 0, 'h20, 0);
    do_cycle("c9C", 0, 0, 1, 0, 0, 'h9C, 0);
    chk("c9C.pc", 32'(pc), 32'h9C);
    do_cycle("ovf_pre_rst", 0, 0, 0, 0, 0, 0, 0);
    do_cycle("c30", 0, 0, 1, 0, 0, 'h30, 0);
    do_cycle("ovf_set", 0, 0, 1, 0, 0, 'h50, 0);
    stall = 1'b0; ret_en = 1'b0; call_en = 1'b0; jump_en = 1'b0;
    branch_en = 1'b0; clr_err = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    #1;
    rst_n = 1'b0;
    do_cycle("ret_after_rst", 0, 1, 0, 0, 0, 0, 0);
    chk("ret_after_rst.pc", 32'(pc), 32'h04);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      do_cycle("rand",
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0,
               int'($urandom_range(0, MOD - 1)),
               $urandom_range(0, 9) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
